// File: rtl/clock_pkg.sv
// clock_pkg
// Shared constants and helpers for the digital-clock datapath.
//   SEC_MOD / MIN_MOD / HR24_MOD / HR12_MOD : moduli for each time field
//   BCD_W                                  : width of one BCD digit
//   bcd_split(value)                       : {tens, ones} for value < 100
package clock_pkg;

  localparam int SEC_MOD  = 60;
  localparam int MIN_MOD  = 60;
  localparam int HR24_MOD = 24;
  localparam int HR12_MOD = 12;

  localparam int BCD_W = 4;

  // Binary-weighted compare/subtract on the tens digit (80, 40, 20, 10).
  // Only valid for value < 100; no general divider is needed.
  function automatic logic [2*BCD_W-1:0] bcd_split(input logic [6:0] value);
    logic [BCD_W-1:0] tens;
    logic [6:0]       rem;
    tens = '0;
    rem  = value;
    if (rem >= 7'd80) begin tens = tens + 4'd8; rem = rem - 7'd80; end
    if (rem >= 7'd40) begin tens = tens + 4'd4; rem = rem - 7'd40; end
    if (rem >= 7'd20) begin tens = tens + 4'd2; rem = rem - 7'd20; end
    if (rem >= 7'd10) begin tens = tens + 4'd1; rem = rem - 7'd10; end
    return {tens, 4'(rem)};
  endfunction

endpackage

// File: rtl/bin2bcd_lt100.sv
// bin2bcd_lt100
// Combinational binary-to-BCD conversion for inputs below 100.
//   bin_i  : binary value, 0..99
//   tens_o : BCD tens digit
//   ones_o : BCD ones digit
module bin2bcd_lt100
  import clock_pkg::*;
(
  input  logic [6:0]       bin_i,
  output logic [BCD_W-1:0] tens_o,
  output logic [BCD_W-1:0] ones_o
);

  assign {tens_o, ones_o} = bcd_split(bin_i);

endmodule

// File: rtl/mod_n_counter.sv
// mod_n_counter
// Modulo-MODULUS time-field counter with up/down stepping, synchronous clear,
// range-checked parallel load and registered BCD digits.
//   clk, rst        : clock, asynchronous active-high reset
//   en, up          : step enable and direction (1 = increment)
//   clr, load, data : clear to RESET_VAL, parallel load of data
//   q               : registered binary count
//   tens, ones      : registered BCD digits of q
//   tc              : combinational terminal count for chaining into the next en
//   load_err        : one-cycle pulse after a load with data >= MODULUS
module mod_n_counter
  import clock_pkg::*;
#(
  parameter int MODULUS   = 24,
  parameter int WIDTH     = $clog2(MODULUS),
  parameter int RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] q,
  output logic [BCD_W-1:0] tens,
  output logic [BCD_W-1:0] ones,
  output logic             tc,
  output logic             load_err
);

  generate
    if (MODULUS < 2 || MODULUS > 100 || RESET_VAL < 0 ||
        RESET_VAL >= MODULUS || (2 ** WIDTH) < MODULUS) begin : g_param_check
      $error("mod_n_counter: illegal MODULUS/WIDTH/RESET_VAL combination");
    end
  endgenerate

  localparam logic [WIDTH-1:0]     MAX_V   = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0]     RST_V   = WIDTH'(RESET_VAL);
  // One extra bit so MODULUS == 2**WIDTH still compares correctly.
  localparam logic [WIDTH:0]       MOD_EXT = (WIDTH + 1)'(MODULUS);
  localparam logic [2*BCD_W-1:0]   RST_BCD = bcd_split(7'(RESET_VAL));

  logic [WIDTH-1:0] count_q, count_d;
  logic             err_q, err_d;
  logic [BCD_W-1:0] tens_q, ones_q;
  logic [BCD_W-1:0] tens_d, ones_d;

  always_comb begin
    count_d = count_q;
    err_d   = 1'b0;
    if (clr) begin
      count_d = RST_V;
    end else if (load) begin
      if ({1'b0, data} >= MOD_EXT) begin
        count_d = RST_V;
        err_d   = 1'b1;
      end else begin
        count_d = data;
      end
    end else if (en) begin
      // Wrap test happens before the step, so q never passes MODULUS-1.
      if (up) begin
        count_d = (count_q == MAX_V) ? '0 : count_q + WIDTH'(1);
      end else begin
        count_d = (count_q == '0) ? MAX_V : count_q - WIDTH'(1);
      end
    end
  end

  // Digits are derived from the next-state value so they update on the same
  // edge as q.
  bin2bcd_lt100 u_bcd (
    .bin_i  (7'(count_d)),
    .tens_o (tens_d),
    .ones_o (ones_d)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= RST_V;
      err_q   <= 1'b0;
      tens_q  <= RST_BCD[2*BCD_W-1:BCD_W];
      ones_q  <= RST_BCD[BCD_W-1:0];
    end else begin
      count_q <= count_d;
      err_q   <= err_d;
      tens_q  <= tens_d;
      ones_q  <= ones_d;
    end
  end

  assign tc       = en & ~clr & ~load & (up ? (count_q == MAX_V) : (count_q == '0));
  assign q        = count_q;
  assign tens     = tens_q;
  assign ones     = ones_q;
  assign load_err = err_q;

endmodule

// File: tb/tb_mod_n_counter.sv
module tb_mod_n_counter;
  import clock_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // MODULUS = 24 instance
  logic a_en = 0, a_up = 0, a_clr = 0, a_load = 0;
  logic [4:0] a_data = '0;
  logic [4:0] a_q;
  logic [3:0] a_tens, a_ones;
  logic a_tc, a_err;

  // MODULUS = 60 instance
  logic b_en = 0, b_up = 0, b_clr = 0, b_load = 0;
  logic [5:0] b_data = '0;
  logic [5:0] b_q;
  logic [3:0] b_tens, b_ones;
  logic b_tc, b_err;

  // 60 -> 60 -> 24 cascade
  logic c_en = 0, c_load = 0;
  logic [5:0] cs_data = '0, cm_data = '0;
  logic [4:0] ch_data = '0;
  logic [5:0] cs_q, cm_q;
  logic [4:0] ch_q;
  logic [3:0] cs_tens, cs_ones, cm_tens, cm_ones, ch_tens, ch_ones;
  logic cs_tc, cm_tc, ch_tc, cs_err, cm_err, ch_err;

  mod_n_counter #(.MODULUS(HR24_MOD)) u_a (
    .clk(clk), .rst(rst), .en(a_en), .up(a_up), .clr(a_clr), .load(a_load),
    .data(a_data), .q(a_q), .tens(a_tens), .ones(a_ones), .tc(a_tc), .load_err(a_err));

  mod_n_counter #(.MODULUS(SEC_MOD)) u_b (
    .clk(clk), .rst(rst), .en(b_en), .up(b_up), .clr(b_clr), .load(b_load),
    .data(b_data), .q(b_q), .tens(b_tens), .ones(b_ones), .tc(b_tc), .load_err(b_err));

  mod_n_counter #(.MODULUS(SEC_MOD)) u_sec (
    .clk(clk), .rst(rst), .en(c_en), .up(1'b1), .clr(1'b0), .load(c_load),
    .data(cs_data), .q(cs_q), .tens(cs_tens), .ones(cs_ones), .tc(cs_tc), .load_err(cs_err));

  mod_n_counter #(.MODULUS(MIN_MOD)) u_min (
    .clk(clk), .rst(rst), .en(cs_tc), .up(1'b1), .clr(1'b0), .load(c_load),
    .data(cm_data), .q(cm_q), .tens(cm_tens), .ones(cm_ones), .tc(cm_tc), .load_err(cm_err));

  mod_n_counter #(.MODULUS(HR24_MOD)) u_hr (
    .clk(clk), .rst(rst), .en(cm_tc), .up(1'b1), .clr(1'b0), .load(c_load),
    .data(ch_data), .q(ch_q), .tens(ch_tens), .ones(ch_ones), .tc(ch_tc), .load_err(ch_err));

  int compared = 0;
  int mismatched = 0;

  // Reference model state (counts as plain integers, RESET_VAL = 0).
  int ma = 0, mb = 0;
  bit ma_err = 0, mb_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int model_next(int qv, int m, bit en, bit up, bit clr, bit ld, int d);
    if (clr) return 0;
    if (ld) return (d < m) ? d : 0;
    if (en) return up ? (qv + 1) % m : (qv + m - 1) % m;
    return qv;
  endfunction

  function automatic bit model_tc(int qv, int m, bit en, bit up, bit clr, bit ld);
    return en && !clr && !ld && (up ? (qv == m - 1) : (qv == 0));
  endfunction

  // Called just after inputs change at a falling edge: checks tc against the
  // model, lets one rising edge happen, then checks all registered outputs.
  task automatic tick();
    int na, nb;
    bit nae, nbe;
    #1;
    check("a_tc", a_tc, model_tc(ma, 24, a_en, a_up, a_clr, a_load));
    check("b_tc", b_tc, model_tc(mb, 60, b_en, b_up, b_clr, b_load));
    na  = model_next(ma, 24, a_en, a_up, a_clr, a_load, int'(a_data));
    nb  = model_next(mb, 60, b_en, b_up, b_clr, b_load, int'(b_data));
    nae = !a_clr && a_load && (int'(a_data) >= 24);
    nbe = !b_clr && b_load && (int'(b_data) >= 60);
    @(posedge clk);
    #1;
    ma = na; mb = nb; ma_err = nae; mb_err = nbe;
    check("a_q", a_q, ma);
    check("a_tens", a_tens, ma / 10);
    check("a_ones", a_ones, ma % 10);
    check("a_err", a_err, ma_err);
    check("b_q", b_q, mb);
    check("b_tens", b_tens, mb / 10);
    check("b_ones", b_ones, mb % 10);
    check("b_err", b_err, mb_err);
  endtask

  task automatic idle();
    a_en = 0; a_up = 0; a_clr = 0; a_load = 0;
    b_en = 0; b_up = 0; b_clr = 0; b_load = 0;
  endtask

  initial begin
    int exp_a [4];
    int exp_b [3];
    bit exp_atc [4];
    bit exp_btc [3];
    exp_a = '{22, 23, 0, 1};
    exp_atc = '{0, 0, 1, 0};
    exp_b = '{0, 59, 58};
    exp_btc = '{0, 1, 0};

    // Reset state
    @(negedge clk); @(negedge clk);
    check("rst_a_q", a_q, 0);
    check("rst_a_err", a_err, 0);
    check("rst_b_q", b_q, 0);
    check("rst_b_digits", {b_tens, b_ones}, 0);
    check("rst_cas_q", {cs_q, cm_q, ch_q}, 0);
    rst = 0;

    // Asynchronous reset mid-cycle with q = 13
    @(negedge clk); idle(); a_load = 1; a_data = 13; tick();
    check("async_pre_q", a_q, 13);
    @(negedge clk); idle();
    #2 rst = 1;
    #1;
    check("async_q", a_q, 0);
    check("async_tens", a_tens, 0);
    check("async_ones", a_ones, 0);
    check("async_err", a_err, 0);
    ma = 0; mb = 0; ma_err = 0; mb_err = 0;
    #1 rst = 0;

    // Up count through the wrap, modulo 24
    @(negedge clk); idle(); a_load = 1; a_data = 21; tick();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); idle(); a_en = 1; a_up = 1;
      #1 check("up24_tc", a_tc, exp_atc[i]);
      tick();
      check("up24_q", a_q, exp_a[i]);
      if (exp_a[i] == 23) begin
        check("up24_tens23", a_tens, 2);
        check("up24_ones23", a_ones, 3);
      end
    end

    // Down count through the wrap, modulo 60
    @(negedge clk); idle(); b_load = 1; b_data = 1; tick();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); idle(); b_en = 1; b_up = 0;
      #1 check("dn60_tc", b_tc, exp_btc[i]);
      tick();
      check("dn60_q", b_q, exp_b[i]);
      if (exp_b[i] == 59) begin
        check("dn60_tens59", b_tens, 5);
        check("dn60_ones59", b_ones, 9);
      end
    end

    // Load range checking, modulo 24
    @(negedge clk); idle(); a_load = 1; a_data = 17; tick();
    check("ld17_q", a_q, 17);
    check("ld17_err", a_err, 0);
    @(negedge clk); idle(); a_load = 1; a_data = 30; tick();
    check("ld30_q", a_q, 0);
    check("ld30_err", a_err, 1);
    @(negedge clk); idle(); tick();
    check("ld_idle_err", a_err, 0);

    // Load beats en; clr beats load (modulo 60)
    @(negedge clk); idle(); b_load = 1; b_data = 59; tick();
    @(negedge clk); idle(); b_load = 1; b_en = 1; b_up = 1; b_data = 5;
    #1 check("ld_en_tc", b_tc, 0);
    tick();
    check("ld_en_q", b_q, 5);
    @(negedge clk); idle(); b_clr = 1; b_load = 1; b_data = 7; tick();
    check("clr_ld_q", b_q, 0);

    // Cascade 59:59:23 -> 00:00:00
    @(negedge clk); idle(); c_en = 0; c_load = 1; cs_data = 59; cm_data = 59; ch_data = 23;
    @(posedge clk); #1;
    check("cas_pre", {cs_q, cm_q, ch_q}, {6'd59, 6'd59, 5'd23});
    @(negedge clk); c_load = 0; c_en = 1;
    #1;
    check("cas_sec_tc", cs_tc, 1);
    check("cas_min_tc", cm_tc, 1);
    check("cas_hr_tc", ch_tc, 1);
    @(posedge clk); #1;
    check("cas_post", {cs_q, cm_q, ch_q}, 0);
    check("cas_digits", {cs_tens, cs_ones, cm_tens, cm_ones, ch_tens, ch_ones}, 0);
    @(negedge clk); c_en = 0;

    // Randomized traffic against the model
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      a_en = 1'($urandom_range(0, 1)); a_up = 1'($urandom_range(0, 1));
      a_clr = ($urandom_range(0, 15) == 0); a_load = ($urandom_range(0, 7) == 0);
      a_data = 5'($urandom_range(0, 31));
      b_en = 1'($urandom_range(0, 1)); b_up = 1'($urandom_range(0, 1));
      b_clr = ($urandom_range(0, 15) == 0); b_load = ($urandom_range(0, 7) == 0);
      b_data = 6'($urandom_range(0, 63));
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
